// File: rtl/surf_trig_framer_pkg.sv
// Shared constants, field positions, framer state type and the frame-word
// composition helper for the SURF->TURF trigger framer.
// Optional build macro: SURF_TRIG_FRAMER_PARITY_EN (even parity in bit 16).
package surf_trig_pkg;

  localparam logic [1:0] TRIG_HDR  = 2'b10;
  localparam logic [7:0] IDLE_BYTE = 8'h00;
  localparam int         FRAME_LEN = 4;
  localparam int         SLOT_LEN  = 8;

  // Field bit positions inside the 32-bit trigger word
  localparam int HDR_MSB  = 31;
  localparam int HDR_LSB  = 30;
  localparam int ADDR_MSB = 29;
  localparam int ADDR_LSB = 18;
  localparam int RSV_BIT  = 17;
  localparam int PAR_BIT  = 16;
  localparam int SEQ_MSB  = 15;
  localparam int SEQ_LSB  = 8;
  localparam int META_MSB = 7;
  localparam int META_LSB = 0;

  // IDLE waits for a slot; B2/B1/B0 name the byte emitted on the next edge
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_B2   = 2'd1,
    ST_B1   = 2'd2,
    ST_B0   = 2'd3
  } framer_state_e;

  // Outgoing word: incoming word with the sequence number dropped into [15:8]
  function automatic logic [31:0] compose_word(input logic [31:0] tdata,
                                               input logic [7:0]  seq);
    logic [31:0] w;
    w = tdata;
    w[SEQ_MSB:SEQ_LSB] = seq;
`ifdef SURF_TRIG_FRAMER_PARITY_EN
    // Bit 17 is forced low so bit 16 makes the whole word even parity
    w[RSV_BIT] = 1'b0;
    w[PAR_BIT] = ^{w[31:17], w[15:0]};
`endif
    return w;
  endfunction

endpackage

// File: rtl/surf_trig_framer.sv
// Serializes accepted 32-bit trigger words onto the byte-wide trigger link,
// one 4-byte MSB-first frame per 8-clock slot, with idle bytes in between.
// Optional build macro: SURF_TRIG_FRAMER_PARITY_EN (see surf_trig_pkg).
//
// Handshake: a word transfers on a rising ifclk edge where s_trig_tvalid and
// s_trig_tready are both high. tready is only offered in the last clock of a
// slot while no frame is in flight, so the upstream must hold tvalid/tdata
// stable until that edge; there is no buffering beyond the latched word.
module surf_trig_framer #(
  parameter int         SLOT_LEN  = surf_trig_pkg::SLOT_LEN,
  parameter int         FRAME_LEN = surf_trig_pkg::FRAME_LEN,
  parameter logic [7:0] IDLE_BYTE = surf_trig_pkg::IDLE_BYTE
) (
  input  logic                         ifclk,
  input  logic                         rst_i,
  input  logic                         runrst_i,
  input  logic                         sync_i,
  input  logic [31:0]                  s_trig_tdata,
  input  logic                         s_trig_tvalid,
  output logic                         s_trig_tready,
  output logic [7:0]                   tx_data_o,
  output logic                         tx_frame_o,
  output logic [31:0]                  sent_count_o,
  output logic [7:0]                   bad_count_o,
  output surf_trig_pkg::framer_state_e dbg_state
);

  import surf_trig_pkg::framer_state_e;
  import surf_trig_pkg::ST_IDLE;
  import surf_trig_pkg::ST_B2;
  import surf_trig_pkg::ST_B1;
  import surf_trig_pkg::ST_B0;
  import surf_trig_pkg::TRIG_HDR;
  import surf_trig_pkg::HDR_MSB;
  import surf_trig_pkg::HDR_LSB;
  import surf_trig_pkg::compose_word;

  localparam int SLOT_W = $clog2(SLOT_LEN);
  localparam int WORD_W = FRAME_LEN * 8;

  framer_state_e     state, state_d;
  logic [SLOT_W-1:0] slot;
  logic [WORD_W-1:0] word_q, word_d;
  logic [WORD_W-1:0] framed;
  logic [7:0]        seq;
  logic [7:0]        tx_data_d;
  logic              tx_frame_d;
  logic              accept;
  logic              good;

  // Ready is withheld during reset so nothing is consumed while state is being cleared
  assign s_trig_tready = !rst_i && (state == ST_IDLE) &&
                         (slot == SLOT_W'(SLOT_LEN - 1)) && !sync_i;
  assign accept    = s_trig_tvalid && s_trig_tready;
  assign good      = accept && (s_trig_tdata[HDR_MSB:HDR_LSB] == TRIG_HDR);
  assign framed    = compose_word(s_trig_tdata, seq);
  assign dbg_state = state;

  // Free-running slot position, realigned to 0 by sync_i
  always_ff @(posedge ifclk) begin
    if (rst_i || sync_i) slot <= '0;
    else                 slot <= slot + SLOT_W'(1);
  end

  // Next-state and next-byte selection for the frame serializer
  always_comb begin
    state_d    = state;
    word_d     = word_q;
    tx_data_d  = IDLE_BYTE;
    tx_frame_d = 1'b0;
    case (state)
      ST_IDLE: begin
        if (good) begin
          word_d     = framed;
          tx_data_d  = framed[31:24];
          tx_frame_d = 1'b1;
          state_d    = ST_B2;
        end
      end
      ST_B2: begin
        tx_data_d = word_q[23:16];
        state_d   = ST_B1;
      end
      ST_B1: begin
        tx_data_d = word_q[15:8];
        state_d   = ST_B0;
      end
      ST_B0: begin
        tx_data_d = word_q[7:0];
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state, latched word and registered link outputs
  always_ff @(posedge ifclk) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      word_q     <= '0;
      tx_data_o  <= IDLE_BYTE;
      tx_frame_o <= 1'b0;
    end else begin
      state      <= state_d;
      word_q     <= word_d;
      tx_data_o  <= tx_data_d;
      tx_frame_o <= tx_frame_d;
    end
  end

  // Sequence number and statistics; run reset wins over same-cycle increments
  always_ff @(posedge ifclk) begin
    if (rst_i || runrst_i) begin
      seq          <= '0;
      sent_count_o <= '0;
      bad_count_o  <= '0;
    end else begin
      if (good) begin
        seq          <= seq + 8'd1;
        sent_count_o <= sent_count_o + 32'd1;
      end
      if (accept && !good && (bad_count_o != 8'hFF)) begin
        bad_count_o <= bad_count_o + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_surf_trig_framer.sv
// Directed bench for surf_trig_framer: a slot/queue model of the link checked
// every cycle, plus literal frame, counter and timing expectations.
module tb_surf_trig_framer;

  import surf_trig_pkg::framer_state_e;
  import surf_trig_pkg::ST_IDLE;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i         = 1'b1;
  logic          runrst_i      = 1'b0;
  logic          sync_i        = 1'b0;
  logic [31:0]   s_trig_tdata  = 32'h0;
  logic          s_trig_tvalid = 1'b0;
  logic          s_trig_tready;
  logic [7:0]    tx_data_o;
  logic          tx_frame_o;
  logic [31:0]   sent_count_o;
  logic [7:0]    bad_count_o;
  framer_state_e dbg_state;

  surf_trig_framer dut (
    .ifclk         (clk),
    .rst_i         (rst_i),
    .runrst_i      (runrst_i),
    .sync_i        (sync_i),
    .s_trig_tdata  (s_trig_tdata),
    .s_trig_tvalid (s_trig_tvalid),
    .s_trig_tready (s_trig_tready),
    .tx_data_o     (tx_data_o),
    .tx_frame_o    (tx_frame_o),
    .sent_count_o  (sent_count_o),
    .bad_count_o   (bad_count_o),
    .dbg_state     (dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // The link is a byte queue: a good word pushes its four bytes, each clock
  // shows one queued byte or idle. The slot is clocks since the last sync mod 8.
  bit          m_valid = 1'b0;
  int          m_slot  = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  e_data  = 8'h00;
  bit          e_frame = 1'b0;
  logic [31:0] e_sent  = 32'h0;
  int          e_bad   = 0;
  logic [7:0]  m_seq   = 8'h00;

  logic [31:0] last_frame  = 32'h0;
  logic [31:0] cap         = 32'h0;
  int          cap_cnt     = 0;
  int          frames_seen = 0;

  function automatic logic [31:0] model_word(input logic [31:0] d, input logic [7:0] s);
    logic [31:0] w;
    w = {d[31:16], s, d[7:0]};
`ifdef SURF_TRIG_FRAMER_PARITY_EN
    w[17] = 1'b0;
    w[16] = 1'b0;
    if (($countones(w) % 2) == 1) w[16] = 1'b1;
`endif
    return w;
  endfunction

  // Compare process: check outputs, capture frames, then advance the model
  always @(negedge clk) begin : mon
    bit          exp_ready;
    logic [31:0] w;
    exp_ready = !rst_i && (exp_q.size() == 0) && (m_slot == 7) && !sync_i;
    if (m_valid) begin
      check("tx_data",    32'(tx_data_o),     32'(e_data));
      check("tx_frame",   32'(tx_frame_o),    32'(e_frame));
      check("sent_count", sent_count_o,       e_sent);
      check("bad_count",  32'(bad_count_o),   32'(e_bad));
      check("tready",     32'(s_trig_tready), 32'(exp_ready));
      if (tx_frame_o) begin
        cap     = {24'h0, tx_data_o};
        cap_cnt = 1;
      end else if (cap_cnt > 0) begin
        cap = {cap[23:0], tx_data_o};
        cap_cnt++;
        if (cap_cnt == 4) begin
          last_frame = cap;
          frames_seen++;
          cap_cnt = 0;
        end
      end
      if (rst_i) cap_cnt = 0;
    end
    if (rst_i) begin
      m_valid = 1'b1;
      m_slot  = 0;
      exp_q.delete();
      e_data  = 8'h00;
      e_frame = 1'b0;
      e_sent  = 32'h0;
      e_bad   = 0;
      m_seq   = 8'h00;
    end else if (m_valid) begin
      m_slot  = sync_i ? 0 : (m_slot + 1) % 8;
      e_frame = 1'b0;
      e_data  = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
      if (s_trig_tvalid && exp_ready) begin
        if (s_trig_tdata[31:30] == 2'b10) begin
          w = model_word(s_trig_tdata, m_seq);
          e_data  = w[31:24];
          e_frame = 1'b1;
          exp_q.push_back(w[23:16]);
          exp_q.push_back(w[15:8]);
          exp_q.push_back(w[7:0]);
          m_seq  = m_seq + 8'd1;
          e_sent = e_sent + 32'd1;
        end else if (e_bad < 255) begin
          e_bad++;
        end
      end
      if (runrst_i) begin
        m_seq  = 8'h00;
        e_sent = 32'h0;
        e_bad  = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; holds the word until the handshake edge has passed.
  // waits counts the clocks the word was offered, including the accepting one.
  task automatic send_word(input logic [31:0] w, input bit rr, output int waits);
    bit done;
    done  = 1'b0;
    waits = 0;
    s_trig_tdata  = w;
    s_trig_tvalid = 1'b1;
    for (int k = 0; k < 40 && !done; k++) begin
      #1;
      waits++;
      if (s_trig_tready) begin
        runrst_i = rr;
        done     = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    s_trig_tvalid = 1'b0;
    runrst_i      = 1'b0;
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL handshake_timeout: word %h never accepted within 40 clocks", w);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_sync();
    sync_i = 1'b1;
    settle(1);
    sync_i = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin : stim
    int waits;
    int fs;
    rst_i = 1'b1;
    settle(3);
    rst_i = 1'b0;
    check("reset_tx_data",  32'(tx_data_o),     32'h00);
    check("reset_tx_frame", 32'(tx_frame_o),    32'h0);
    check("reset_tready",   32'(s_trig_tready), 32'h0);
    check("reset_sent",     sent_count_o,       32'h0);
    check("reset_bad",      32'(bad_count_o),   32'h0);
    check("reset_state",    32'(dbg_state),     32'(ST_IDLE));

    // First word after sync: ready exactly at slot 7
    pulse_sync();
    send_word(32'h8123_0042, 1'b0, waits);
    check("sync_to_ready", 32'(waits), 32'd8);
    settle(5);
    check("frame_first", last_frame, 32'h8123_0042);
    check("sent_one",    sent_count_o, 32'd1);

    send_word(32'h8123_0042, 1'b0, waits);
    settle(5);
    check("frame_seq1", last_frame, 32'h8123_0142);

    // Sequence numbers 2..255, then the wrap back to 0
    for (int i = 0; i < 254; i++) begin
      send_word({2'b10, 12'(i * 7), 2'b00, 8'h00, 8'(i)}, 1'b0, waits);
    end
    send_word(32'h8123_0042, 1'b0, waits);
    settle(5);
    check("frame_seq_wrap", last_frame, 32'h8123_0042);
    check("sent_257",       sent_count_o, 32'd257);

    // Bad headers: dropped, counted, saturating
    fs = frames_seen;
    send_word(32'h4000_0011, 1'b0, waits);
    settle(5);
    check("bad_one",       32'(bad_count_o), 32'd1);
    check("bad_no_frame",  32'(frames_seen), 32'(fs));
    check("bad_link_idle", 32'(tx_data_o),   32'h00);
    for (int i = 0; i < 299; i++) begin
      send_word({((i % 3) == 0) ? 2'b00 : (((i % 3) == 1) ? 2'b01 : 2'b11),
                 30'(i * 13)}, 1'b0, waits);
    end
    settle(2);
    check("bad_saturate", 32'(bad_count_o), 32'd255);

    // Sync during the third byte: frame completes, ready 8 clocks after sync
    fs = frames_seen;
    send_word(32'h8ABC_0077, 1'b0, waits);
    settle(1);
    pulse_sync();
    send_word(32'h8123_0042, 1'b0, waits);
    check("midframe_sync_ready", 32'(waits), 32'd8);
    settle(5);
    check("midframe_sync_frames", 32'(frames_seen), 32'(fs + 2));
    check("after_sync_frame",     last_frame, 32'h8123_0242);

    // Run reset coincident with the handshake of the seq=5 word
    runrst_i = 1'b1;
    settle(1);
    runrst_i = 1'b0;
    for (int i = 0; i < 5; i++) send_word(32'h8040_0000 | 32'(i), 1'b0, waits);
    send_word(32'h8123_0042, 1'b1, waits);
    settle(5);
    check("runrst_frame_seq5", last_frame,   32'h8123_0542);
    check("runrst_sent_clear", sent_count_o, 32'd0);
    send_word(32'h8123_0042, 1'b0, waits);
    settle(5);
    check("runrst_frame_seq0", last_frame,   32'h8123_0042);
    check("runrst_sent_one",   sent_count_o, 32'd1);

    // Reset in the middle of a frame abandons it
    fs = frames_seen;
    send_word(32'h8555_0066, 1'b0, waits);
    settle(1);
    rst_i = 1'b1;
    settle(1);
    rst_i = 1'b0;
    check("midrst_tx_data",  32'(tx_data_o),  32'h00);
    check("midrst_tx_frame", 32'(tx_frame_o), 32'h0);
    check("midrst_sent",     sent_count_o,    32'd0);
    check("midrst_state",    32'(dbg_state),  32'(ST_IDLE));
    settle(4);
    check("midrst_no_frame", 32'(frames_seen), 32'(fs));

    // Reserved/parity bits
    send_word(32'h8003_0001, 1'b0, waits);
    settle(5);
`ifdef SURF_TRIG_FRAMER_PARITY_EN
    check("parity_word_a",  last_frame, 32'h8000_0001);
    check("parity_even_a",  32'($countones(last_frame) % 2), 32'd0);
`else
    check("passthru_word_a", last_frame, 32'h8003_0001);
`endif
    send_word(32'h8000_0007, 1'b0, waits);
    settle(5);
`ifdef SURF_TRIG_FRAMER_PARITY_EN
    check("parity_word_b",  last_frame, 32'h8001_0107);
    check("parity_even_b",  32'($countones(last_frame) % 2), 32'd0);
`else
    check("passthru_word_b", last_frame, 32'h8000_0107);
`endif

    settle(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Bound on total run time
  initial begin : watchdog
    #2000000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
